// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-wide data memory port: byte/half/word loads with
// extension, read-modify-write sub-word stores. Optional macro: MISALIGN_TRAP_EN.
module dmem_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  // state   | meaning
  // IDLE    | ready for a request
  // LOAD    | memory read, extended lane captured into resp_rdata
  // STORE_W | full-word write
  // RMW_RD  | read target word, merge new lane
  // RMW_WR  | write merged word
  // RESP    | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, RESP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   merge_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                accept;
  logic                misalign;
  logic [1:0]          size_norm;
  logic [7:0]          lane8;
  logic [15:0]         lane16;
  logic [DATA_W-1:0]   load_ext;
  logic [DATA_W-1:0]   merged;

  assign req_ready = rst_n && (state_q == IDLE);
  assign accept    = req_valid && req_ready;

`ifdef MISALIGN_TRAP_EN
  logic err_q;

  assign misalign  = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                     (req_size == 2'b11);
  assign size_norm = req_size;
  assign resp_err  = (state_q == RESP) && err_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (accept)
      err_q <= misalign;
  end
`else
  assign misalign  = 1'b0;
  // Reserved size behaves as a word access when trapping is disabled.
  assign size_norm = (req_size == 2'b11) ? 2'b10 : req_size;
  assign resp_err  = 1'b0;
`endif

  assign lane8  = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
  assign lane16 = mem_read_data[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = mem_read_data;
    case (size_q)
      2'b00:   load_ext = uns_q ? {{(DATA_W-8){1'b0}}, lane8}
                                : {{(DATA_W-8){lane8[7]}}, lane8};
      2'b01:   load_ext = uns_q ? {{(DATA_W-16){1'b0}}, lane16}
                                : {{(DATA_W-16){lane16[15]}}, lane16};
      default: load_ext = mem_read_data;
    endcase
  end

  always_comb begin
    merged = mem_read_data;
    if (size_q == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misalign)
            state_d = RESP;
          else if (!req_we)
            state_d = LOAD;
          else if (size_norm[1] == 1'b0)
            state_d = RMW_RD;
          else
            state_d = STORE_W;
        end
      end
      LOAD:    state_d = RESP;
      STORE_W: state_d = RESP;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q  <= size_norm;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end
      if (state_q == LOAD)
        rdata_q <= load_ext;
      if (state_q == RMW_RD)
        merge_q <= merged;
    end
  end

  always_comb begin
    mem_addr       = '0;
    mem_write      = 1'b0;
    mem_write_data = '0;
    case (state_q)
      LOAD, RMW_RD: mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
      STORE_W: begin
        mem_addr       = {addr_q[ADDR_W-1:2], 2'b00};
        // Gated by rst_n so a reset edge never coincides with a memory write.
        mem_write      = rst_n;
        mem_write_data = rst_n ? wdata_q : '0;
      end
      RMW_WR: begin
        mem_addr       = {addr_q[ADDR_W-1:2], 2'b00};
        mem_write      = rst_n;
        mem_write_data = rst_n ? merge_q : '0;
      end
      default: ;
    endcase
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a small word memory model on the memory port.
module tb_dmem_lsu;
  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic [31:0] mem_read_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:15];
  int          wr_cnt = 0;
  int          resp_cnt = 0;
  logic [31:0] last_wa, last_wd;
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx;
  logic [31:0] pl_data;

  // per-request results
  logic [31:0] r_data;
  logic        r_err, r_vld;
  int          r_lat, r_wd;

  dmem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (mem_write) begin
      mem[mem_addr[5:2]] <= mem_write_data;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_addr;
      last_wd <= mem_write_data;
    end
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  task automatic set_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_idx = a[5:2]; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int w0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    w0 = wr_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    r_lat = 0;
    while (!resp_valid && r_lat < 8) begin
      @(posedge clk); #1;
      r_lat++;
    end
    r_vld  = resp_valid;
    r_data = resp_rdata;
    r_err  = resp_err;
    @(posedge clk); #1;
    r_wd = wr_cnt - w0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write: got %b exp 0", mem_write); end
    checks++; if (mem_addr !== 32'h0 || resp_rdata !== 32'h0) begin errors++;
      $display("FAIL rst_zero: mem_addr %h rdata %h exp 0", mem_addr, resp_rdata); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b exp 1", req_ready); end
  endtask

  task automatic test_word();
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    checks++; if (r_vld !== 1'b1 || r_lat != 1) begin errors++; $display("FAIL sw_lat: vld %b lat %0d exp 1/1", r_vld, r_lat); end
    checks++; if (r_wd != 1) begin errors++; $display("FAIL sw_writes: got %0d exp 1", r_wd); end
    checks++; if (last_wa !== 32'h10 || last_wd !== 32'hDEADBEEF) begin errors++;
      $display("FAIL sw_data: addr %h data %h exp 00000010 deadbeef", last_wa, last_wd); end
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (r_vld !== 1'b1 || r_lat != 1) begin errors++; $display("FAIL lw_lat: vld %b lat %0d exp 1/1", r_vld, r_lat); end
    checks++; if (r_data !== 32'hDEADBEEF || r_err !== 1'b0) begin errors++;
      $display("FAIL lw_data: got %h err %b exp deadbeef 0", r_data, r_err); end
    checks++; if (r_wd != 0) begin errors++; $display("FAIL lw_nowrite: got %0d exp 0", r_wd); end
  endtask

  task automatic test_byte();
    set_word(32'h10, 32'hDEADBEEF);
    run_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AA);
    checks++; if (r_vld !== 1'b1 || r_lat != 2) begin errors++; $display("FAIL sb_lat: vld %b lat %0d exp 1/2", r_vld, r_lat); end
    checks++; if (r_wd != 1 || last_wd !== 32'hAAADBEEF) begin errors++;
      $display("FAIL sb_merge: writes %0d data %h exp 1 aaadbeef", r_wd, last_wd); end
    checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL sb_rdata: got %h exp 0", r_data); end
    run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    checks++; if (r_data !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb_13: got %h exp ffffffaa", r_data); end
    run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    checks++; if (r_data !== 32'h000000AA) begin errors++; $display("FAIL lbu_13: got %h exp 000000aa", r_data); end
    run_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    checks++; if (r_data !== 32'hFFFFFFBE) begin errors++; $display("FAIL lb_11: got %h exp ffffffbe", r_data); end
    set_word(32'h20, 32'h11223344);
    run_req(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF55);
    checks++; if (last_wa !== 32'h20 || last_wd !== 32'h11225544) begin errors++;
      $display("FAIL sb_21: addr %h data %h exp 00000020 11225544", last_wa, last_wd); end
  endtask

  task automatic test_half();
    set_word(32'h10, 32'h11223344);
    run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234);
    checks++; if (r_lat != 2 || r_wd != 1 || last_wd !== 32'h12343344) begin errors++;
      $display("FAIL sh_12: lat %0d writes %0d data %h exp 2 1 12343344", r_lat, r_wd, last_wd); end
    run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    checks++; if (r_data !== 32'h00001234) begin errors++; $display("FAIL lh_12: got %h exp 00001234", r_data); end
    set_word(32'h10, 32'hFFFF8000);
    run_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    checks++; if (r_data !== 32'hFFFF8000) begin errors++; $display("FAIL lh_10: got %h exp ffff8000", r_data); end
    run_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    checks++; if (r_data !== 32'h00008000) begin errors++; $display("FAIL lhu_10: got %h exp 00008000", r_data); end
    run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    checks++; if (r_data !== 32'h0000FFFF) begin errors++; $display("FAIL lhu_12: got %h exp 0000ffff", r_data); end
  endtask

  task automatic test_misalign();
    set_word(32'h10, 32'hCAFEF00D);
    run_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
`ifdef MISALIGN_TRAP_EN
    checks++; if (r_vld !== 1'b1 || r_lat != 0) begin errors++; $display("FAIL mis_lat: vld %b lat %0d exp 1/0", r_vld, r_lat); end
    checks++; if (r_err !== 1'b1 || r_data !== 32'h0) begin errors++;
      $display("FAIL mis_err: err %b data %h exp 1 0", r_err, r_data); end
    run_req(1'b1, 2'b01, 1'b0, 32'h11, 32'h5555);
    checks++; if (r_err !== 1'b1 || r_wd != 0) begin errors++;
      $display("FAIL mis_sh: err %b writes %0d exp 1 0", r_err, r_wd); end
`else
    checks++; if (r_vld !== 1'b1 || r_lat != 1) begin errors++; $display("FAIL mis_lat: vld %b lat %0d exp 1/1", r_vld, r_lat); end
    checks++; if (r_err !== 1'b0 || r_data !== 32'hCAFEF00D) begin errors++;
      $display("FAIL mis_data: err %b data %h exp 0 cafef00d", r_err, r_data); end
    run_req(1'b0, 2'b01, 1'b1, 32'h13, 32'h0);
    checks++; if (r_err !== 1'b0 || r_data !== 32'h0000CAFE) begin errors++;
      $display("FAIL mis_lhu: err %b data %h exp 0 0000cafe", r_err, r_data); end
`endif
    checks++; if (r_wd != 0) begin errors++; $display("FAIL mis_nowrite: got %0d exp 0", r_wd); end
  endtask

  task automatic test_reset_abort();
    int w0, rc0;
    set_word(32'h10, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h99;
    w0 = wr_cnt; rc0 = resp_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b0 || mem_write !== 1'b0) begin errors++;
      $display("FAIL abort_in_rst: ready %b mem_write %b exp 0 0", req_ready, mem_write); end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (wr_cnt != w0 || resp_cnt != rc0) begin errors++;
      $display("FAIL abort_quiet: writes %0d resps %0d exp 0 0", wr_cnt - w0, resp_cnt - rc0); end
    checks++; if (mem[4] !== 32'h11223344) begin errors++; $display("FAIL abort_mem: got %h exp 11223344", mem[4]); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b exp 1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
